// File: rtl/product_accumulator.sv
// Signed product accumulator: sums a block of products terminated by in_last,
// saturating at the ACC_W range, and holds the result in a ready/valid output register.
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     sum_wide;
  logic               add_ovf;
  logic [ACC_W-1:0]   acc_sat;
  logic [CNT_W-1:0]   cnt_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear)       state_d = IDLE;
    else if (accept) state_d = in_last ? IDLE : ACCUM;
  end

  // Output logic: the input side stalls only while a held sum is not draining
  always_comb begin
    in_ready  = !out_valid_q || out_ready;
    accept    = in_valid && in_ready && !clear;
    out_valid = out_valid_q;
    out_sum   = out_sum_q;
    out_count = out_count_q;
    out_ovf   = out_ovf_q;
  end

  // One extra bit of headroom detects leaving the signed ACC_W range
  always_comb begin
    prod_ext = {{(ACC_W + 1 - PROD_W){in_product[PROD_W-1]}}, in_product};
    sum_wide = {acc_q[ACC_W-1], acc_q} + prod_ext;
    add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!add_ovf)            acc_sat = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W]) acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
    else                      acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
    cnt_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
  end

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clear || (accept && in_last)) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      acc_d   = acc_sat;
      count_d = cnt_inc;
      ovf_d   = ovf_q | add_ovf;
    end

    // A new last product reloads over a draining sum without dropping out_valid
    if (accept && in_last) begin
      out_valid_d = 1'b1;
      out_sum_d   = acc_sat;
      out_count_d = cnt_inc;
      out_ovf_d   = ovf_q | add_ovf;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed, table-driven bench for product_accumulator with hand-written
// sequences for stall, saturation and mid-block reset.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_product;
  logic        in_last;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  product_accumulator #(
    .PROD_W(64),
    .ACC_W (72),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .in_last   (in_last),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] prod;
    logic        last;
    logic        clr;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [71:0] exp_sum;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic v, input longint prod, input logic last,
                              input logic clr, input logic ordy, input logic ir,
                              input logic ov, input longint sum, input int cnt,
                              input logic ovf);
    vec_t r;
    r.v = v; r.prod = prod; r.last = last; r.clr = clr; r.ordy = ordy;
    r.exp_ir = ir; r.exp_ov = ov; r.exp_sum = 72'(sum);
    r.exp_cnt = 8'(cnt); r.exp_ovf = ovf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] p, input logic last,
                       input logic clr, input logic ordy);
    in_valid = v; in_product = p; in_last = last; clear = clr; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [71:0] sum, input int cnt,
                         input logic ovf);
    chk({tag, "_valid"}, 72'(out_valid), 72'(1'b1));
    chk({tag, "_sum"},   out_sum, sum);
    chk({tag, "_count"}, 72'(out_count), 72'(cnt));
    chk({tag, "_ovf"},   72'(out_ovf), 72'(ovf));
  endtask

  logic [71:0] sat_max;
  logic [71:0] held_sum;

  initial begin
    sat_max = {1'b0, {71{1'b1}}};

    vecs[0]  = mk(1,   5, 0, 0, 1, 1, 0,   0, 0, 0);
    vecs[1]  = mk(1,  -3, 0, 0, 1, 1, 0,   0, 0, 0);
    vecs[2]  = mk(1,  10, 1, 0, 1, 1, 1,  12, 3, 0);
    vecs[3]  = mk(0,   0, 0, 0, 1, 1, 0,   0, 0, 0);
    vecs[4]  = mk(1,   7, 1, 0, 1, 1, 1,   7, 1, 0);
    vecs[5]  = mk(1,  -7, 1, 0, 1, 1, 1,  -7, 1, 0);
    vecs[6]  = mk(0,   0, 0, 0, 1, 1, 0,   0, 0, 0);
    vecs[7]  = mk(1, 100, 1, 0, 0, 1, 1, 100, 1, 0);
    vecs[8]  = mk(0,   0, 0, 0, 0, 0, 1, 100, 1, 0);
    vecs[9]  = mk(0,   0, 0, 1, 0, 0, 1, 100, 1, 0);
    vecs[10] = mk(1,   4, 0, 0, 1, 1, 0,   0, 0, 0);
    vecs[11] = mk(1,   6, 0, 0, 1, 1, 0,   0, 0, 0);
    vecs[12] = mk(1,  99, 1, 1, 1, 1, 0,   0, 0, 0);
    vecs[13] = mk(1,   1, 1, 0, 0, 1, 1,   1, 1, 0);
    vecs[14] = mk(0,   0, 0, 0, 1, 1, 0,   0, 0, 0);

    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0);
    #2;
    chk("rst_out_valid", 72'(out_valid), 72'(1'b0));
    chk("rst_out_sum",   out_sum, '0);
    chk("rst_out_count", 72'(out_count), '0);
    chk("rst_out_ovf",   72'(out_ovf), '0);
    chk("rst_in_ready",  72'(in_ready), 72'(1'b1));
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].prod, vecs[i].last, vecs[i].clr, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 72'(in_ready), 72'(vecs[i].exp_ir));
      step();
      chk($sformatf("vec%0d_out_valid", i), 72'(out_valid), 72'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) begin
        chk($sformatf("vec%0d_sum", i),   out_sum, vecs[i].exp_sum);
        chk($sformatf("vec%0d_count", i), 72'(out_count), 72'(vecs[i].exp_cnt));
        chk($sformatf("vec%0d_ovf", i),   72'(out_ovf), 72'(vecs[i].exp_ovf));
      end
    end

    // Stall: held sum, a non-last product offered must not be consumed
    drive(1, 64'd20, 1, 0, 0);
    step();
    chk_out("stall_load", 72'd20, 1, 0);
    held_sum = out_sum;
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'd3, 0, 0, 0);
      #1;
      chk($sformatf("stall%0d_in_ready", i), 72'(in_ready), 72'(1'b0));
      step();
      chk_out($sformatf("stall%0d", i), held_sum, 1, 0);
    end
    drive(1, 64'd3, 0, 0, 1);
    #1;
    chk("release_in_ready", 72'(in_ready), 72'(1'b1));
    step();
    chk("release_drained", 72'(out_valid), 72'(1'b0));
    drive(1, 64'd2, 1, 0, 1);
    step();
    chk_out("after_stall", 72'd5, 2, 0);
    drive(0, '0, 0, 0, 1);
    step();
    chk("after_stall_drain", 72'(out_valid), 72'(1'b0));

    // Positive saturation and count saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1);
      step();
    end
    chk("sat_mid_valid", 72'(out_valid), 72'(1'b0));
    drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 1);
    step();
    chk_out("sat", sat_max, 255, 1);
    drive(0, '0, 0, 0, 1);
    step();
    chk("sat_drain", 72'(out_valid), 72'(1'b0));

    // Asynchronous reset in the middle of a block
    drive(1, 64'd11, 0, 0, 1);
    step();
    drive(1, 64'd12, 0, 0, 1);
    step();
    drive(0, '0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 72'(out_valid), 72'(1'b0));
    chk("mid_rst_in_ready",  72'(in_ready), 72'(1'b1));
    step();
    chk("mid_rst_hold_valid", 72'(out_valid), 72'(1'b0));
    rst_n = 1'b1;
    drive(1, 64'd9, 1, 0, 1);
    step();
    chk_out("post_rst", 72'd9, 1, 0);
    drive(0, '0, 0, 0, 1);
    step();
    chk("post_rst_drain", 72'(out_valid), 72'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
